mdu_hilo: RTL

- Multiply/divide unit that receives the hilo enables (hien, loen) and the mult/div operation select from the decoded-instruction stage.
- Holds the architectural HI and LO registers and runs multi-cycle mult/multu/div/divu.
- Sits in the EX stage beside the ALU and exposes busy so hazard logic can stall mfhi/mflo/mthi/mtlo and further md ops.

---
 rtl/mdu_hilo_if.sv | 23 ++
 rtl/mdu_hilo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the EX-stage issue logic and the HI/LO multiply-divide unit.
// master drives operation requests and mt writes; slave returns busy and the HI/LO contents.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  md_op;
  logic        hien;
  logic        loen;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, hien, loen, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, hien, loen, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle mult/multu/div/divu unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu (accumulate into {HI,LO}); otherwise those codes are reserved.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_hilo_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          opOk;
  logic          isDiv;
  logic          divZero;
  logic          lastCycle;
  logic [63:0]   extA;
  logic [63:0]   extB;
  logic [63:0]   prod;
  logic          aNeg;
  logic          bNeg;
  logic [31:0]   aMag;
  logic [31:0]   bMag;
  logic [31:0]   divisor;
  logic [31:0]   qMag;
  logic [31:0]   rMag;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic [63:0]   res_d;

  always_comb begin
    opOk = 1'b0;
    case (bus.md_op)
      3'b000, 3'b001, 3'b010, 3'b011: opOk = 1'b1;
`ifdef MDU_MADD_EN
      3'b100, 3'b101:                 opOk = 1'b1;
`endif
      default:                        opOk = 1'b0;
    endcase
  end

  // Odd op codes are the unsigned variants, so op_q[0] alone selects operand extension.
  always_comb begin
    isDiv   = (op_q[2:1] == 2'b01);
    divZero = isDiv && (b_q == 32'd0);
    extA    = {(op_q[0] ? 32'd0 : {32{a_q[31]}}), a_q};
    extB    = {(op_q[0] ? 32'd0 : {32{b_q[31]}}), b_q};
    prod    = extA * extB;
  end

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no trap.
  always_comb begin
    aNeg    = ~op_q[0] & a_q[31];
    bNeg    = ~op_q[0] & b_q[31];
    aMag    = aNeg ? (32'd0 - a_q) : a_q;
    bMag    = bNeg ? (32'd0 - b_q) : b_q;
    divisor = (bMag == 32'd0) ? 32'd1 : bMag;
    qMag    = aMag / divisor;
    rMag    = aMag % divisor;
    quot    = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
    rem     = aNeg ? (32'd0 - rMag) : rMag;
  end

  always_comb begin
    res_d = prod;
    if (isDiv) begin
      res_d = {rem, quot};
    end
`ifdef MDU_MADD_EN
    if (op_q[2]) begin
      res_d = {hi_q, lo_q} + prod;
    end
`endif
  end

  assign lastCycle = (cnt_q == (isDiv ? DIV_N : MULT_N));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && opOk) begin
            state_q <= BUSY;
            cnt_q   <= CW'(1);
            op_q    <= bus.md_op;
            a_q     <= bus.rs_data;
            b_q     <= bus.rt_data;
          end else begin
            if (bus.hien) hi_q <= bus.rs_data;
            if (bus.loen) lo_q <= bus.rs_data;
          end
        end
        BUSY: begin
          if (lastCycle) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (!divZero) begin
              hi_q <= res_d[63:32];
              lo_q <= res_d[31:0];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
